loopback_arbiter: RTL and testbench

- Single-clock controller in the wclk domain of the dual-FIFO loopback wrapper.
- Shares the forward FIFO write port between two requesters using round-robin bursts.
- Limits the number of beats in flight with a credit counter.
- Reads the return FIFO and routes each returned beat to the requester that sent it; routing comes from an in-order tag queue.

---
 rtl/loopback_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_loopback_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_arbiter.sv
// ============================================================================
// Module      : loopback_arbiter
// Description : Round-robin burst arbiter for the forward FIFO write port,
//               with credit-limited issue and tag-routed return responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loopback_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4,
    parameter int MAX_OUT    = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  wen,
    output logic [DATA_WIDTH-1:0] din,
    input  logic                  full,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  empty,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  busy
);

    localparam int c_PTR_W  = $clog2(MAX_OUT);
    localparam int c_BEAT_W = $clog2(BURST + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT0 = 2'd1;
    localparam logic [1:0] c_ST_GRANT1 = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_MAX_OUT = CNT_WIDTH'(MAX_OUT);
    localparam logic [c_BEAT_W-1:0]  c_BURST   = c_BEAT_W'(BURST);

    logic [1:0]            r_state;
    logic                  r_prio;        // 0: requester 0 wins a tie
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_outstanding;
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;
    logic                  r_tag_mem [MAX_OUT];
    logic                  r_rd_pend;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic [1:0]            w_state_nxt;
    logic                  w_prio_nxt;
    logic [c_BEAT_W-1:0]   w_beat_nxt;
    logic [c_BEAT_W-1:0]   w_beat_inc;
    logic                  w_sel;
    logic                  w_cur_valid;
    logic                  w_oth_valid;
    logic                  w_credit_ok;
    logic                  w_acc;
    logic                  w_last;
    logic                  w_ren;
    logic                  w_head_tag;

    assign w_sel       = (r_state == c_ST_GRANT1);
    assign w_cur_valid = w_sel ? req1_valid : req0_valid;
    assign w_oth_valid = w_sel ? req0_valid : req1_valid;
    assign w_credit_ok = (r_outstanding < c_MAX_OUT);
    assign w_beat_inc  = r_beat_cnt + 1'b1;
    assign w_head_tag  = r_tag_mem[r_rd_ptr[c_PTR_W-1:0]];

    // Every outstanding beat owns exactly one tag not yet claimed by a read,
    // so a non-zero count is the same as "an unclaimed tag exists".
    assign w_ren = ~empty & (r_outstanding != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_beat_nxt  = r_beat_cnt;
        w_acc       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (req0_valid && req1_valid)
                    w_state_nxt = r_prio ? c_ST_GRANT1 : c_ST_GRANT0;
                else if (req0_valid)
                    w_state_nxt = c_ST_GRANT0;
                else if (req1_valid)
                    w_state_nxt = c_ST_GRANT1;
            end
            c_ST_GRANT0, c_ST_GRANT1: begin
                w_acc  = w_cur_valid & ~full & w_credit_ok;
                w_last = w_acc & (w_beat_inc == c_BURST);
                if (w_acc)
                    w_beat_nxt = w_beat_inc;
                // Stalls on full/credit hold everything; only a finished
                // burst or a dropped valid hands over the port.
                if (w_last || !w_cur_valid) begin
                    w_prio_nxt = ~w_sel;
                    w_beat_nxt = '0;
                    if (w_oth_valid)
                        w_state_nxt = w_sel ? c_ST_GRANT0 : c_ST_GRANT1;
                    else if (w_cur_valid)
                        w_state_nxt = r_state;
                    else
                        w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_acc, w_ren})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge wclk) begin
        if (w_acc)
            r_tag_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_sel;
    end

    // The read issued last cycle owns the head tag; its data arrives now.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_pend    <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_rd_pend    <= w_ren;
            r_rsp0_valid <= r_rd_pend & ~w_head_tag;
            r_rsp1_valid <= r_rd_pend & w_head_tag;
            if (w_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_rd_pend) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_rsp_data <= dout;
            end
        end
    end

    assign req0_ready  = w_acc & ~w_sel;
    assign req1_ready  = w_acc & w_sel;
    assign wen         = w_acc;
    assign din         = w_sel ? req1_data : req0_data;
    assign ren         = w_ren;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp_data    = r_rsp_data;
    assign outstanding = r_outstanding;
    assign busy        = (r_state != c_ST_IDLE) | (r_outstanding != '0);

endmodule

`default_nettype wire

// File: tb/tb_loopback_arbiter.sv
// ============================================================================
// Module      : tb_loopback_arbiter
// Description : Directed bench for loopback_arbiter with a looped-back FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loopback_arbiter;

    logic       wclk = 1'b0;
    logic       rst  = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       wen, ren, full = 1'b0, empty;
    logic [7:0] din;
    logic [7:0] dout = 8'h00;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_data;
    logic [3:0] outstanding;
    logic       busy;

    logic       hold_ret = 1'b0;
    logic       stray    = 1'b0;
    logic [7:0] lq[$];
    int         lq_cnt = 0;
    int         n_vec  = 0;
    int         n_err  = 0;

    always #5 wclk = ~wclk;

    loopback_arbiter #(
        .DATA_WIDTH(8), .BURST(4), .MAX_OUT(8), .CNT_WIDTH(4)
    ) dut (
        .wclk(wclk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .wen(wen), .din(din), .full(full),
        .ren(ren), .dout(dout), .empty(empty),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .outstanding(outstanding), .busy(busy)
    );

    // Forward and return FIFO collapsed into one loopback queue.
    assign empty = hold_ret | (~stray & (lq_cnt == 0));

    always @(posedge wclk) begin
        if (rst) begin
            lq.delete();
        end else begin
            if (ren) begin
                if (lq.size() > 0) dout <= lq.pop_front();
                else               dout <= 8'h00;
            end
            if (wen) lq.push_back(din);
        end
        lq_cnt <= lq.size();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge wclk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; full = 1'b0;
        hold_ret = 1'b0; stray = 1'b0;
        repeat (2) @(negedge wclk);
        rst = 1'b0;
    endtask

    logic [7:0] t2_d0  [13] = '{8'h10,8'h10,8'h11,8'h12,8'h13,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14};
    logic [7:0] t2_d1  [13] = '{8'h20,8'h20,8'h20,8'h20,8'h20,8'h20,8'h21,8'h22,8'h23,8'h24,8'h24,8'h24,8'h24};
    logic       t2_wen [13] = '{0,1,1,1,1,1,1,1,1,1,0,0,0};
    logic       t2_rd1 [13] = '{0,0,0,0,0,1,1,1,1,0,0,0,0};
    logic [7:0] t2_din [13] = '{8'h00,8'h10,8'h11,8'h12,8'h13,8'h20,8'h21,8'h22,8'h23,8'h14,8'h00,8'h00,8'h00};
    logic       t2_r0  [13] = '{0,0,0,0,1,1,1,1,0,0,0,0,1};
    logic       t2_r1  [13] = '{0,0,0,0,0,0,0,0,1,1,1,1,0};
    logic [7:0] t2_rd  [13] = '{8'h00,8'h00,8'h00,8'h00,8'h10,8'h11,8'h12,8'h13,8'h20,8'h21,8'h22,8'h23,8'h14};

    initial begin
        // ---- reset values ----
        repeat (2) @(negedge wclk);
        settle();
        chk("rst_wen", 32'(wen), 0);
        chk("rst_ren", 32'(ren), 0);
        chk("rst_rdy0", 32'(req0_ready), 0);
        chk("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // ---- req0 alone: A1,A2,A3 with return path held ----
        hold_ret = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hA1; settle();
        chk("t1_bubble", 32'(wen), 0);
        for (int m = 1; m <= 3; m++) begin
            @(negedge wclk); req0_data = 8'hA0 + 8'(m); settle();
            chk("t1_wen", 32'(wen), 1);
            chk("t1_rdy0", 32'(req0_ready), 1);
            chk("t1_din", 32'(din), 32'(8'hA0 + 8'(m)));
        end
        @(negedge wclk); req0_valid = 1'b0; settle();
        chk("t1_wen_off", 32'(wen), 0);
        chk("t1_out3", 32'(outstanding), 3);
        @(negedge wclk); hold_ret = 1'b0; settle();
        chk("t1_ren", 32'(ren), 1);
        @(negedge wclk); settle();
        chk("t1_norsp", 32'(rsp0_valid), 0);
        for (int m = 1; m <= 3; m++) begin
            @(negedge wclk); settle();
            chk("t1_rsp0", 32'(rsp0_valid), 1);
            chk("t1_rsp1", 32'(rsp1_valid), 0);
            chk("t1_rdata", 32'(rsp_data), 32'(8'hA0 + 8'(m)));
        end
        @(negedge wclk); settle();
        chk("t1_rsp_end", 32'(rsp0_valid), 0);
        chk("t1_hold", 32'(rsp_data), 32'hA3);
        chk("t1_idle", 32'(busy), 0);

        // ---- both valid: 4+4 bursts, return routing ----
        apply_reset();
        for (int m = 0; m < 13; m++) begin
            if (m > 0) @(negedge wclk);
            req0_valid = (m < 10); req1_valid = (m < 10);
            req0_data = t2_d0[m]; req1_data = t2_d1[m];
            settle();
            chk("t2_wen", 32'(wen), 32'(t2_wen[m]));
            chk("t2_rdy1", 32'(req1_ready), 32'(t2_rd1[m]));
            chk("t2_rdy0", 32'(req0_ready), 32'(t2_wen[m] & ~t2_rd1[m]));
            if (t2_wen[m]) chk("t2_din", 32'(din), 32'(t2_din[m]));
            chk("t2_rsp0", 32'(rsp0_valid), 32'(t2_r0[m]));
            chk("t2_rsp1", 32'(rsp1_valid), 32'(t2_r1[m]));
            if (t2_r0[m] | t2_r1[m]) chk("t2_rdata", 32'(rsp_data), 32'(t2_rd[m]));
        end

        // ---- full for 5 cycles mid-burst, then async reset at outstanding=5 ----
        apply_reset();
        hold_ret = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h30;
        @(negedge wclk); settle();
        chk("t3_din0", 32'(din), 32'h30);
        @(negedge wclk);
        req0_data = 8'h31; full = 1'b1; req1_valid = 1'b1; req1_data = 8'h40;
        for (int m = 0; m < 5; m++) begin
            if (m > 0) @(negedge wclk);
            settle();
            chk("t3_full_wen", 32'(wen), 0);
            chk("t3_full_rdy", 32'({req0_ready, req1_ready}), 0);
        end
        @(negedge wclk); full = 1'b0; settle();
        chk("t3_resume", 32'(din), 32'h31);
        chk("t3_rdy0", 32'(req0_ready), 1);
        for (int m = 2; m <= 3; m++) begin
            @(negedge wclk); req0_data = 8'h30 + 8'(m); settle();
            chk("t3_din", 32'(din), 32'(8'h30 + 8'(m)));
        end
        @(negedge wclk); req0_data = 8'h60; settle();
        chk("t3_rot_rdy1", 32'(req1_ready), 1);
        chk("t3_rot_din", 32'(din), 32'h40);
        chk("t3_out4", 32'(outstanding), 4);
        @(negedge wclk); settle();
        chk("t3_out5", 32'(outstanding), 5);
        rst = 1'b1; settle();
        chk("t3_arst_out", 32'(outstanding), 0);
        chk("t3_arst_wen", 32'(wen), 0);
        chk("t3_arst_rdy", 32'({req0_ready, req1_ready}), 0);
        chk("t3_arst_busy", 32'(busy), 0);
        @(negedge wclk); rst = 1'b0; hold_ret = 1'b0; settle();
        chk("t3_post_bubble", 32'(wen), 0);
        @(negedge wclk); settle();
        chk("t3_post_rdy", 32'({req0_ready, req1_ready}), 32'b10);
        chk("t3_post_din", 32'(din), 32'h60);

        // ---- credit limit: 8 beats with return held, then release ----
        apply_reset();
        hold_ret = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h50;
        for (int m = 1; m <= 8; m++) begin
            @(negedge wclk); req0_data = 8'h50 + 8'(m - 1); settle();
            chk("t4_wen", 32'(wen), 1);
            chk("t4_din", 32'(din), 32'(8'h50 + 8'(m - 1)));
        end
        @(negedge wclk); req0_data = 8'h58; settle();
        chk("t4_out8", 32'(outstanding), 8);
        chk("t4_nocredit", 32'({req0_ready, wen}), 0);
        @(negedge wclk); hold_ret = 1'b0; settle();
        chk("t4_ren", 32'(ren), 1);
        chk("t4_wen_stall", 32'(wen), 0);
        @(negedge wclk); settle();
        chk("t4_both", 32'({wen, ren}), 32'b11);
        chk("t4_din58", 32'(din), 32'h58);
        chk("t4_out7", 32'(outstanding), 7);
        @(negedge wclk); req0_data = 8'h59; settle();
        chk("t4_out_const", 32'(outstanding), 7);
        chk("t4_rsp0", 32'(rsp0_valid), 1);
        chk("t4_rdata", 32'(rsp_data), 32'h50);

        // ---- stray return data with nothing outstanding ----
        apply_reset();
        stray = 1'b1;
        for (int m = 0; m < 3; m++) begin
            @(negedge wclk); settle();
            chk("t5_ren", 32'(ren), 0);
            chk("t5_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
            chk("t5_out", 32'(outstanding), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
